vga_scan_compositor: RTL and testbench
======================================

// Module: vga_scan_compositor
// PURPOSE
// - Drives the VGA scan for the fighter display: generates the pixel coordinates consumed
//   by the sprite ROM block and collects that block's pixel reply one fixed latency later.
// - Composites the sprite pixel over a background pixel, expands RGB332 to 8:8:8 for the
//   DAC, and emits latency-aligned hsync, vsync and blank.
// - Provides a frame_start tick and a frame counter so game logic can update state once
//   per frame.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_FP     16  : horizontal front porch, in pixels
// - H_SYNC   96  : hsync pulse width, in pixels
// - H_BP     48  : horizontal back porch, in pixels
// - V_ACTIVE 480 : visible lines
// - V_FP     10  : vertical front porch, in lines
// - V_SYNC   2   : vsync pulse width, in lines
// - V_BP     33  : vertical back porch, in lines
// - LATENCY  2   : clk cycles from current_pixel_x/y out to data/visible_flag/bg_data valid in; range 1..4
// PORTS
// - clk              in   1   pixel clock, 25.175 MHz nominal; all logic on posedge
// - rst              in   1   asynchronous, active-low reset
// - current_pixel_x  out  10  horizontal scan count, 0..H_TOTAL-1
// - current_pixel_y  out  10  vertical scan count, 0..V_TOTAL-1
// - data             in   8   sprite pixel in RGB332, valid LATENCY cycles after its coordinate
// - visible_flag     in   1   1 = sprite pixel is opaque, aligned with data
// - bg_data          in   8   background pixel in RGB332, aligned with data
// - vga_r            out  8   red to DAC
// - vga_g            out  8   green to DAC
// - vga_b            out  8   blue to DAC
// - hsync            out  1   horizontal sync, active low
// - vsync            out  1   vertical sync, active low
// - blank_n          out  1   1 = active video
// - frame_start      out  1   one-cycle pulse at the start of each frame
// - frame_count      out  8   number of completed frames, wraps at 256
// BEHAVIOUR
// - Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
// - Reset values while rst=0:
//   - x, y, rgb, blank_n, frame_start, frame_count = 0
//   - hsync = vsync = 1
//   - every delay-line stage is cleared to the inactive state
//   - reset may assert mid-frame; on release the scan restarts at (0,0).
// - Scan counters, stage S0, registered outputs:
//   - x increments every cycle; at H_TOTAL-1, x wraps to 0 and y increments.
//   - y wraps to 0 after V_TOTAL-1.
// - Raw timing for the coordinate currently driven:
//   - active = (x < H_ACTIVE) && (y < V_ACTIVE)
//   - hs_n = 0 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//   - vs_n = 0 for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
// - Alignment:
//   - active, hs_n and vs_n pass through a LATENCY-deep shift register to reach the stage
//     where data, visible_flag and bg_data for the same coordinate arrive.
//   - One output register follows. Coordinate at cycle t appears on the vga_* pins,
//     hsync, vsync and blank_n at cycle t+LATENCY+1.
// - Composite, in the output stage:
//   - if the delayed active bit is 0: pixel = 8'h00
//   - else if visible_flag = 1: pixel = data
//   - else: pixel = bg_data
//   - blank_n = delayed active bit.
// - RGB332 expansion of pixel p:
//   - vga_r = {p[7:5], p[7:5], p[7:6]}
//   - vga_g = {p[4:2], p[4:2], p[4:3]}
//   - vga_b = {4{p[1:0]}}
// - Frame tick:
//   - frame_start = 1 for exactly one cycle, in the cycle the counters show (0,0) after
//     wrapping from (H_TOTAL-1, V_TOTAL-1).
//   - No pulse for the first frame after reset.
//   - frame_count increments in the same cycle and wraps 255 -> 0.
// - Inputs received during blanking are ignored. Sprite and background sources receive
//   blanking coordinates (x >= 640 or y >= 480) and must tolerate them.
// TESTING
// - Reset, then 800 cycles with LATENCY=2:
//   - x sweeps 0..799 then returns to 0, and y = 1
//   - hsync is low for exactly 96 cycles, starting when x=656 is observed at cycle t,
//     on the pins at t+3
// - Full frame of 420000 cycles:
//   - vsync is low for 1600 cycles
//   - frame_start pulses once, at cycle 420000 after reset release
//   - frame_count = 1
// - Latency model returning data = x[7:0], visible_flag = 1 after 2 cycles:
//   - coordinate (5,0) yields vga_r/g/b of pixel 8'h05 on the pins at t+3
//   - out-of-order or misaligned pixels are a fail
// - visible_flag = 0, bg_data = 8'h1C -> vga_g = 8'hFF, vga_r = vga_b = 0.
// - data = 8'hE3, visible_flag = 1 -> vga_r = 8'hFF, vga_g = 0, vga_b = 8'hFF.
// - Blanking and reset:
//   - drive data = 8'hFF during x >= 640 -> rgb = 0, blank_n = 0
//   - pull rst low at (300,200) -> all outputs return to reset values asynchronously;
//     on release the scan restarts at (0,0) with no frame_start

Source files
------------

// File: rtl/vga_scan_compositor.sv
// vga_scan_compositor
// Free-running VGA scan generator. The current coordinate goes out to the sprite ROM
// block, whose pixel reply returns LATENCY clocks later. The sprite pixel is composited
// over the background, RGB332 is expanded to 8:8:8 for the DAC, and the sync/blank
// timing is delayed so it stays aligned with the pixel it belongs to.
// A frame_start tick and a wrapping frame counter are provided for the game logic.
module vga_scan_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LATENCY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] current_pixel_x,
    output logic [9:0] current_pixel_y,
    input  logic [7:0] data,
    input  logic       visible_flag,
    input  logic [7:0] bg_data,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    // scan counters (stage S0)
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       frame_wrap;

    // raw timing of the coordinate currently on the pins
    logic act_raw;
    logic hs_raw_n;
    logic vs_raw_n;

    // delay lines carrying timing to the stage where the pixel reply arrives
    logic [LATENCY-1:0] act_sr_q, act_sr_d;
    logic [LATENCY-1:0] hs_sr_q,  hs_sr_d;
    logic [LATENCY-1:0] vs_sr_q,  vs_sr_d;

    // output stage
    logic       act_dly;
    logic [7:0] pix;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_q, blank_d;

    // frame tick
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    // Next scan position: x runs every cycle, y steps at end of line, both wrap.
    always_comb begin
        x_d        = x_q + 10'd1;
        y_d        = y_q;
        frame_wrap = (x_q == H_LAST) && (y_q == V_LAST);
        if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end
    end

    // Decode active area and sync pulses for the coordinate presented this cycle.
    always_comb begin
        act_raw  = (x_q < H_ACT_END) && (y_q < V_ACT_END);
        hs_raw_n = !((x_q >= HS_BEG) && (x_q < HS_END));
        vs_raw_n = !((y_q >= VS_BEG) && (y_q < VS_END));
    end

    // Shift the timing bits one stage; the oldest bit lines up with the pixel reply.
    always_comb begin
        act_sr_d = (act_sr_q << 1) | LATENCY'(act_raw);
        hs_sr_d  = (hs_sr_q  << 1) | LATENCY'(hs_raw_n);
        vs_sr_d  = (vs_sr_q  << 1) | LATENCY'(vs_raw_n);
    end

    // Composite sprite over background, force black in blanking, expand RGB332.
    always_comb begin
        act_dly = act_sr_q[LATENCY-1];
        if (!act_dly) begin
            pix = 8'h00;
        end else if (visible_flag) begin
            pix = data;
        end else begin
            pix = bg_data;
        end
        r_d     = {pix[7:5], pix[7:5], pix[7:6]};
        g_d     = {pix[4:2], pix[4:2], pix[4:3]};
        b_d     = {4{pix[1:0]}};
        hsync_d = hs_sr_q[LATENCY-1];
        vsync_d = vs_sr_q[LATENCY-1];
        blank_d = act_dly;
    end

    // Frame tick fires as the counters land on (0,0) after the last pixel of a frame,
    // so the very first frame after reset produces no pulse.
    always_comb begin
        fs_d = frame_wrap;
        fc_d = frame_wrap ? fc_q + 8'd1 : fc_q;
    end

    // Scan counter and frame tick registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q  <= 10'd0;
            y_q  <= 10'd0;
            fs_q <= 1'b0;
            fc_q <= 8'd0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fs_q <= fs_d;
            fc_q <= fc_d;
        end
    end

    // Timing delay lines; cleared to blank with both syncs deasserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_sr_q <= '0;
            hs_sr_q  <= '1;
            vs_sr_q  <= '1;
        end else begin
            act_sr_q <= act_sr_d;
            hs_sr_q  <= hs_sr_d;
            vs_sr_q  <= vs_sr_d;
        end
    end

    // Output register feeding the DAC and sync pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            b_q     <= 8'h00;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
        end
    end

    assign current_pixel_x = x_q;
    assign current_pixel_y = y_q;
    assign vga_r           = r_q;
    assign vga_g           = g_q;
    assign vga_b           = b_q;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign blank_n         = blank_q;
    assign frame_start     = fs_q;
    assign frame_count     = fc_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Bench for vga_scan_compositor: full-size instance for pixel path and line timing,
// plus a tiny-timing instance so frame-level behaviour fits in a short run.
module tb_vga_scan_compositor;

    localparam int HT = 800;
    localparam int VT = 525;
    // tiny instance timing
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int SHT = SHA + SHF + SHS + SHB;   // 16
    localparam int SVT = SVA + SVF + SVS + SVB;   // 8

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] px, py;
    logic [7:0] data, bg;
    logic       vis;
    logic [7:0] r, g, b;
    logic       hs, vs, bn, fs;
    logic [7:0] fc;

    logic [9:0] spx, spy;
    logic [7:0] sr, sg, sb;
    logic       shs, svs, sbn, sfs;
    logic [7:0] sfc;

    vga_scan_compositor dut (
        .clk(clk), .rst(rst),
        .current_pixel_x(px), .current_pixel_y(py),
        .data(data), .visible_flag(vis), .bg_data(bg),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .hsync(hs), .vsync(vs), .blank_n(bn),
        .frame_start(fs), .frame_count(fc)
    );

    vga_scan_compositor #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .LATENCY(2)
    ) dut_s (
        .clk(clk), .rst(rst),
        .current_pixel_x(spx), .current_pixel_y(spy),
        .data(8'h00), .visible_flag(1'b0), .bg_data(8'h00),
        .vga_r(sr), .vga_g(sg), .vga_b(sb),
        .hsync(shs), .vsync(svs), .blank_n(sbn),
        .frame_start(sfs), .frame_count(sfc)
    );

    typedef struct {
        logic [7:0] er, eg, eb;
        logic       ehs, evs, ebn;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] bgv;
        logic [7:0] er, eg, eb;
    } vec_t;

    exp_t sbq[$];
    int   hx[$], hy[$];
    int   shx[$], shy[$];
    vec_t tbl[6];
    vec_t cur_vec;

    int total, bad;
    int cyc;
    int mode;
    int mx, my, smx, smy;
    logic fs_exp, sfs_exp;
    int fc_exp, sfc_exp;
    int hs_low, first_hs, svs_low, first_sfs, fs_pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

    task automatic reset_models();
        mx = 0; my = 0; smx = 0; smy = 0;
        fs_exp = 1'b0; sfs_exp = 1'b0;
        fc_exp = 0; sfc_exp = 0;
        hx.delete(); hy.delete(); shx.delete(); shy.delete();
        sbq.delete();
        cyc = 0;
    endtask

    // Called once per cycle at the falling edge: check, then drive, then advance models.
    task automatic step();
        exp_t e;
        int ox, oy, sox, soy;
        logic act;
        logic [7:0] p;
        logic [23:0] rgb;

        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("pixel", 32'({r, g, b, hs, vs, bn}), 32'({e.er, e.eg, e.eb, e.ehs, e.evs, e.ebn}));
        end

        chk("coord", 32'({px, py}), 32'({mx[9:0], my[9:0]}));
        chk("frame_start", 32'(fs), 32'(fs_exp));
        chk("frame_count", 32'(fc), fc_exp);
        chk("s_coord", 32'({spx, spy}), 32'({smx[9:0], smy[9:0]}));
        chk("s_frame_start", 32'(sfs), 32'(sfs_exp));
        chk("s_frame_count", 32'(sfc), sfc_exp);
        chk("s_rgb", 32'({sr, sg, sb}), 32'h0);

        if (fs) fs_pulses++;
        if (!hs) begin
            hs_low++;
            if (first_hs < 0) first_hs = cyc;
        end
        if (cyc < SHT * SVT && !svs) svs_low++;
        if (sfs && first_sfs < 0) first_sfs = cyc;

        // tiny instance: sync/blank of coordinate t-3 on the pins now
        shx.push_back(smx); shy.push_back(smy);
        if (shx.size() > 3) begin
            sox = shx.pop_front(); soy = shy.pop_front();
            chk("s_timing", 32'({shs, svs, sbn}),
                32'({!(sox >= SHA + SHF && sox < SHA + SHF + SHS),
                     !(soy >= SVA + SVF && soy < SVA + SVF + SVS),
                     (sox < SHA) && (soy < SVA)}));
        end

        // latency model: reply for coordinate t-2 presented now
        hx.push_back(mx); hy.push_back(my);
        if (hx.size() > 2) begin
            ox = hx.pop_front(); oy = hy.pop_front();
            case (mode)
                0: begin data = ox[7:0]; vis = 1'b1; bg = 8'($urandom); end
                1: begin data = cur_vec.d; vis = cur_vec.v; bg = cur_vec.bgv; end
                2: begin data = 8'hFF; vis = 1'b1; bg = 8'hFF; end
                default: begin data = 8'($urandom); vis = 1'($urandom); bg = 8'($urandom); end
            endcase
            act = (ox < 640) && (oy < 480);
            p   = !act ? 8'h00 : (vis ? data : bg);
            rgb = expand(p);
            if (mode == 1 && act) rgb = {cur_vec.er, cur_vec.eg, cur_vec.eb};
            e.er  = rgb[23:16];
            e.eg  = rgb[15:8];
            e.eb  = rgb[7:0];
            e.ehs = !(ox >= 656 && ox < 752);
            e.evs = !(oy >= 490 && oy < 492);
            e.ebn = act;
            e.due = cyc + 1;
            sbq.push_back(e);
        end else begin
            data = 8'h00; vis = 1'b0; bg = 8'h00;
        end

        fs_exp = (mx == HT - 1) && (my == VT - 1);
        if (fs_exp) fc_exp = (fc_exp + 1) % 256;
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end

        sfs_exp = (smx == SHT - 1) && (smy == SVT - 1);
        if (sfs_exp) sfc_exp = (sfc_exp + 1) % 256;
        if (smx == SHT - 1) begin
            smx = 0;
            smy = (smy == SVT - 1) ? 0 : smy + 1;
        end else begin
            smx++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        total = 0; bad = 0; mode = 0; cyc = 0;
        data = 8'h00; vis = 1'b0; bg = 8'h00;
        hs_low = 0; first_hs = -1; svs_low = 0; first_sfs = -1; fs_pulses = 0;

        //            data   vis   bg     r      g      b
        tbl[0] = '{8'hE3, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        tbl[1] = '{8'h00, 1'b0, 8'h1C, 8'h00, 8'hFF, 8'h00};
        tbl[2] = '{8'h5A, 1'b1, 8'hFF, 8'h49, 8'hDB, 8'hAA};
        tbl[3] = '{8'hA5, 1'b0, 8'h96, 8'h92, 8'hB6, 8'hAA};
        tbl[4] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        tbl[5] = '{8'h24, 1'b0, 8'h24, 8'h24, 8'h24, 8'h00};
        cur_vec = tbl[0];

        repeat (3) @(negedge clk);
        chk("rst_coord", 32'({px, py}), 32'h0);
        chk("rst_rgb", 32'({r, g, b}), 32'h0);
        chk("rst_sync", 32'({hs, vs, bn, fs}), 32'b1100);
        chk("rst_fc", 32'(fc), 32'h0);

        reset_models();
        rst = 1'b1;

        // line 0: latency model data = x[7:0]
        mode = 0;
        for (int i = 0; i < 803; i++) begin
            if (cyc == 8) chk("lat_pixel05", 32'({r, g, b}), 32'h002455);
            if (cyc == 800) chk("line_wrap", 32'({px, py}), 32'({10'd0, 10'd1}));
            step();
            @(negedge clk);
            cyc++;
        end
        chk("hsync_low_len", hs_low, 96);
        chk("hsync_first", first_hs, 659);

        // line 1: composite table
        mode = 1;
        for (int i = 0; i < 6; i++) begin
            cur_vec = tbl[i];
            run(100);
            chk("tbl_rgb", 32'({r, g, b}), 32'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
        end

        // all-ones inputs across blanking
        mode = 2;
        run(1000);

        // random traffic long enough for the tiny instance to wrap frame_count
        mode = 3;
        run(33000);
        chk("s_first_frame_start", first_sfs, SHT * SVT);
        chk("s_vsync_low_len", svs_low, SHT * SVS);

        // reset mid-line at x = 300
        guard = 0;
        while (mx != 300 && guard < 2000) begin
            step();
            @(negedge clk);
            cyc++;
            guard++;
        end
        chk("reach_x300", 32'(px), 32'd300);
        rst = 1'b0;
        #1;
        chk("arst_coord", 32'({px, py}), 32'h0);
        chk("arst_rgb", 32'({r, g, b}), 32'h0);
        chk("arst_sync", 32'({hs, vs, bn, fs}), 32'b1100);
        chk("arst_fc", 32'({fc, sfc}), 32'h0);
        repeat (2) @(negedge clk);
        reset_models();
        fs_pulses = 0;
        rst = 1'b1;
        run(300);
        chk("no_fs_after_rst", fs_pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
